// File: rtl/led_pkg.sv
// Shared types and helpers for the LED share arbiter.
package led_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_e;

  localparam int LED_COUNT = 5;
  localparam int MAX_REQ   = 32;

  // Round-robin pick: first set bit searching last+1, last+2, ... modulo nreq.
  // Scanning offsets from high to low lets the smallest offset win. Returns
  // last when nothing is requested.
  function automatic int unsigned rr_pick(input logic [MAX_REQ-1:0] req,
                                          input int unsigned last,
                                          input int unsigned nreq);
    int unsigned pick;
    int unsigned idx;
    pick = last;
    for (int unsigned off = MAX_REQ; off > 0; off--) begin
      if (off <= nreq) begin
        idx = (last + off) % nreq;
        if (req[idx[4:0]]) pick = idx;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/led_share_arbiter_pwm.sv
// Brightness gate for the LED bus: free-running counter compared with bright.
// Instantiated only when LED_PWM_DIM_EN is defined.
module led_pwm #(
  parameter int LEDS     = 5,
  parameter int PWM_BITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PWM_BITS-1:0] bright,
  input  logic [LEDS-1:0]     led_i,
  output logic [LEDS-1:0]     led_o
);

  logic [PWM_BITS-1:0] pwm_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_cnt_q <= '0;
    else        pwm_cnt_q <= pwm_cnt_q + 1'b1;
  end

  assign led_o = led_i & {LEDS{pwm_cnt_q < bright}};

endmodule

// File: rtl/led_share_arbiter.sv
// Round-robin owner of the user LEDs; each grant holds for 2**HOLD_LOG2 cycles
// or until early release. Optional dimming with macro LED_PWM_DIM_EN.
//   state | meaning
//   IDLE  | LEDs dark, arbitrating among pending requests
//   SHOW  | rr_last_q owns the LEDs, slot timer running
module led_share_arbiter
  import led_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int LEDS      = LED_COUNT,
  parameter int HOLD_LOG2 = 22,
  parameter int PWM_BITS  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*LEDS-1:0] pattern,
`ifdef LED_PWM_DIM_EN
  input  logic [PWM_BITS-1:0]  bright,
`endif
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic [LEDS-1:0]      led,
  output logic                 busy
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     rr_last_q, rr_last_d;
  logic [HOLD_LOG2-1:0] timer_q, timer_d;
  logic [NREQ-1:0]      gnt_q, gnt_d;
  logic [NREQ-1:0]      done_q, done_d;
  logic [LEDS-1:0]      led_q, led_d;
  logic                 slot_end;

  // Full-length expiry and early release coincide into one end event.
  assign slot_end = (state_q == SHOW) && ((&timer_q) || !req[rr_last_q]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_last_q <= IDX_W'(NREQ - 1);
      timer_q   <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      led_q     <= '0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      timer_q   <= timer_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      led_q     <= led_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    timer_d   = timer_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d   = SHOW;
          rr_last_d = IDX_W'(rr_pick(MAX_REQ'(req), 32'(rr_last_q), NREQ));
          timer_d   = '0;
        end
      end
      SHOW: begin
        timer_d = timer_q + 1'b1;
        if (slot_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d  = '0;
    done_d = '0;
    led_d  = '0;
    case (state_q)
      IDLE: begin
        if (|req) gnt_d = {{(NREQ-1){1'b0}}, 1'b1} << rr_last_d;
      end
      SHOW: begin
        if (slot_end) begin
          done_d = {{(NREQ-1){1'b0}}, 1'b1} << rr_last_q;
        end else begin
          gnt_d = gnt_q;
          led_d = pattern[int'(rr_last_q)*LEDS +: LEDS];
        end
      end
      default: ;
    endcase
  end

  assign gnt  = gnt_q;
  assign done = done_q;
  assign busy = |gnt_q;

`ifdef LED_PWM_DIM_EN
  led_pwm #(
    .LEDS     (LEDS),
    .PWM_BITS (PWM_BITS)
  ) u_pwm (
    .clk    (clk),
    .rst_n  (rst_n),
    .bright (bright),
    .led_i  (led_q),
    .led_o  (led)
  );
`else
  assign led = led_q;
`endif

endmodule
